// File: rtl/led_word_serializer_pkg.sv
// led_word_serializer_pkg: state encoding, 10 kHz tick defaults and counter sizing
// shared by the LED word serializer files.
package led_word_serializer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, SHIFT = 2'd2} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_BIT_TICKS = 1252;
    localparam int DEF_GAP_TICKS = 5000;
    function automatic int tick_w(input int a, input int b);
        return $clog2(a > b ? a : b) + 1;
    endfunction
endpackage

// File: rtl/led_word_serializer_if.sv
// led_word_serializer_if: word handshake plus LED/status outputs of the serializer.
interface led_word_serializer_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data;
    logic valid;
    logic ready;
    logic led;
    logic busy;
    logic done;
    modport master (output data, valid, input ready, led, busy, done);
    modport slave (input data, valid, output ready, led, busy, done);
endinterface

// File: rtl/led_word_serializer_tick_counter.sv
// led_word_serializer_tick_counter: counts enabled cycles up to term, pulsing expire
// on the last one; clr reloads it on every state entry.
module led_word_serializer_tick_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         expire
);
    logic [W-1:0] cnt;
    assign expire = en && (cnt == term - 1'b1);
    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_word_serializer.sv
// led_word_serializer: accepts one word by valid/ready and plays it LSB first on a
// registered LED, each bit held BIT_TICKS cycles after a GAP_TICKS low preamble.
module led_word_serializer
    import led_word_serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BIT_TICKS = DEF_BIT_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS
) (
    input logic clk,
    input logic rst_n,
    led_word_serializer_if.slave s
);
    localparam int TW = tick_w(BIT_TICKS, GAP_TICKS);
    localparam int BW = $clog2(WIDTH) + 1;
    state_t state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [BW-1:0] bit_cnt, bit_d;
    logic led_q, led_d, busy_q, busy_d, done_q, done_d;
    logic clr, expire;
    logic [TW-1:0] term;
    assign term = (state == GAP) ? TW'(GAP_TICKS) : TW'(BIT_TICKS);
    led_word_serializer_tick_counter #(.W(TW)) ticks (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .en(state == GAP || state == SHIFT), .term(term), .expire(expire)
    );
    assign s.ready = (state == IDLE);
    assign s.led = led_q;
    assign s.busy = busy_q;
    assign s.done = done_q;
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= IDLE;
            sr <= '0;
            bit_cnt <= '0;
            led_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state <= state_d;
            sr <= sr_d;
            bit_cnt <= bit_d;
            led_q <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    // led is registered, so each transition loads the value the next cycle must show
    always_comb begin
        state_d = state;
        sr_d = sr;
        bit_d = bit_cnt;
        led_d = led_q;
        busy_d = busy_q;
        done_d = 1'b0;
        clr = 1'b0;
        case (state)
            IDLE: if (s.valid) begin
                sr_d = s.data;
                bit_d = '0;
                clr = 1'b1;
                busy_d = 1'b1;
                state_d = (GAP_TICKS == 0) ? SHIFT : GAP;
                led_d = (GAP_TICKS == 0) ? s.data[0] : 1'b0;
            end
            GAP: if (expire) begin
                state_d = SHIFT;
                clr = 1'b1;
                led_d = sr[0];
            end
            SHIFT: if (expire) begin
                clr = 1'b1;
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    led_d = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    sr_d = sr >> 1;
                    bit_d = bit_cnt + 1'b1;
                    led_d = sr[1];
                end
            end
            default: begin
                state_d = IDLE;
                led_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_led_word_serializer.sv
// tb_led_word_serializer: directed and random frames checked cycle by cycle against
// a timeline model of {led, busy, done, ready}.
module tb_led_word_serializer;
    localparam int W = 32, BT = 4, GT = 8;
    logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
    int checks = 0, errors = 0, dones = 0, frames = 0;
    always #5 clk = ~clk;
    led_word_serializer_if #(.WIDTH(W)) a ();
    led_word_serializer_if #(.WIDTH(W)) b ();
    led_word_serializer #(.WIDTH(W), .BIT_TICKS(BT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst_n(rst_n), .s(a)
    );
    led_word_serializer #(.WIDTH(W), .BIT_TICKS(1), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst_n(rst2_n), .s(b)
    );
    always @(negedge clk) if (a.done === 1'b1) dones++;

    // Expected {led, busy, done, ready} in cycle t after the handshake edge
    function automatic logic [3:0] model(input logic [W-1:0] word, input int t,
                                         input int gap, input int bt);
        int last;
        last = 1 + gap + W * bt;
        if (t >= last) return {1'b0, 1'b0, t == last, 1'b1};
        return {t > gap ? word[(t - 1 - gap) / bt] : 1'b0, 3'b100};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input logic [W-1:0] word, input bit hold, input bit scramble,
                        input string tag);
        a.data = word;
        a.valid = 1'b1;
        frames++;
        for (int t = 1; t <= 1 + GT + W * BT; t++) begin
            @(negedge clk);
            chk($sformatf("%s t=%0d", tag, t), {a.led, a.busy, a.done, a.ready},
                model(word, t, GT, BT));
            if (!hold) a.valid = 1'b0;
            if (scramble) a.data = $urandom;
        end
    endtask

    initial begin
        logic [W-1:0] w;
        a.valid = 1'b1;
        a.data = $urandom;
        b.valid = 1'b0;
        b.data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset c%0d", i), {a.led, a.busy, a.done, a.ready}, 4'b0001);
        end
        a.valid = 1'b0;
        rst_n = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);
        chk("after reset idle", {a.led, a.busy, a.done, a.ready}, 4'b0001);
        play(32'h34D51531, 1'b0, 1'b0, "single");
        play(32'hFFFFFFFF, 1'b1, 1'b0, "b2b first");
        play(32'h00000000, 1'b0, 1'b0, "b2b second");
        play(32'hCB2AEACF, 1'b0, 1'b1, "stable");
        for (int i = 0; i < 3; i++) play($urandom, 1'b0, 1'($urandom_range(0, 1)), "random");
        w = $urandom;
        a.data = w;
        a.valid = 1'b1;
        for (int t = 1; t <= 2 + GT + 13 * BT; t++) begin
            @(negedge clk);
            chk($sformatf("pre-abort t=%0d", t), {a.led, a.busy, a.done, a.ready},
                model(w, t, GT, BT));
            a.valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort", {a.led, a.busy, a.done, a.ready}, 4'b0001);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort idle", {a.led, a.busy, a.done, a.ready}, 4'b0001);
        play($urandom, 1'b0, 1'b0, "after abort");
        @(negedge clk);
        chk("final idle", {a.led, a.busy, a.done, a.ready}, 4'b0001);
        chk("done count", dones, frames);
        b.data = 32'h00000001;
        b.valid = 1'b1;
        for (int t = 1; t <= 34; t++) begin
            @(negedge clk);
            chk($sformatf("nogap t=%0d", t), {b.led, b.busy, b.done, b.ready},
                model(32'h00000001, t, 0, 1));
            b.valid = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
